// File: rtl/mul_sequencer.sv
// Multi-cycle sequencer that drives an external 32x32 unsigned multiplier and owns HI/LO.
// Optional signed support is compiled in when MUL_SIGNED_EN is defined.
module mul_sequencer #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_low,
    input  logic [31:0] mul_high,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  state_dbg
);

    // Handshake: start is taken only while busy=0 (IDLE); busy stays high from LOAD
    // through FIX; done pulses for exactly one cycle once HI/LO hold the product.
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, FIX} state_t;

    state_t      state, state_nx;
    logic [31:0] a_q, b_q;
    logic        sgn_q;
    logic        neg;
    logic [3:0]  cnt;
    logic [31:0] mag_a, mag_b;
    logic        neg_c;
    logic [63:0] prod, prod_fix;

    assign prod      = {mul_high, mul_low};
    assign busy      = (state != IDLE);
    assign state_dbg = state;

`ifdef MUL_SIGNED_EN
    // 0x80000000 negates to itself, which is already its unsigned magnitude.
    assign mag_a    = (sgn_q && a_q[31]) ? (~a_q + 32'd1) : a_q;
    assign mag_b    = (sgn_q && b_q[31]) ? (~b_q + 32'd1) : b_q;
    assign neg_c    = sgn_q & (a_q[31] ^ b_q[31]);
    assign prod_fix = neg ? (~prod + 64'd1) : prod;
`else
    assign mag_a    = a_q;
    assign mag_b    = b_q;
    assign neg_c    = 1'b0 & sgn_q;
    assign prod_fix = prod;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    state_nx = WAIT;
            WAIT:    if (cnt == 4'd0) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            neg   <= 1'b0;
            cnt   <= '0;
            mul_a <= '0;
            mul_b <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= (state == FIX);
            if (state == IDLE) begin
                if (start) begin
                    a_q   <= op_a;
                    b_q   <= op_b;
                    sgn_q <= op_signed;
                end
                // A direct write in the start cycle lands now; FIX overwrites it later.
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
            if (state == LOAD) begin
                mul_a <= mag_a;
                mul_b <= mag_b;
                neg   <= neg_c;
                cnt   <= 4'(MUL_CYCLES - 1);
            end
            if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (state == FIX) begin
                hi <= prod_fix[63:32];
                lo <= prod_fix[31:0];
            end
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer with a behavioural model of the external multiplier.
// Expectations follow MUL_SIGNED_EN when it is defined for the build.
module tb_mul_sequencer;

    localparam int MC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, op_signed, hi_we, lo_we;
    logic [31:0] op_a, op_b, wdata;
    logic [31:0] mul_a, mul_b, mul_low, mul_high, hi, lo;
    logic        busy, done;
    logic [1:0]  state_dbg;

    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          done_cnt = 0;
    logic        prev_done = 1'b0;

    mul_sequencer #(.MUL_CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .start(start), .op_signed(op_signed),
        .op_a(op_a), .op_b(op_b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .mul_a(mul_a), .mul_b(mul_b), .mul_low(mul_low), .mul_high(mul_high),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .state_dbg(state_dbg)
    );

    // External unsigned multiplier
    assign {mul_high, mul_low} = {32'd0, mul_a} * {32'd0, mul_b};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
`ifdef MUL_SIGNED_EN
        if (s) return 64'(sa * sb);
`endif
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request from an IDLE cycle and returns in the cycle where done is seen.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat, output int bcnt);
        exp_q.push_back(model(a, b, s));
        op_a = a; op_b = b; op_signed = s; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1; bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    // Scoreboard: pop on every done pulse.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            check("done_single_cycle", 64'(prev_done), 64'd0);
            if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
            else check("hilo", {hi, lo}, exp_q.pop_front());
        end
        prev_done = done;
    end

    initial begin
        int lat, bcnt, dc;
        logic [31:0] a, b;
        rst = 1'b1; start = 1'b0; op_signed = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op_a = '0; op_b = '0; wdata = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_state", 64'(state_dbg), 64'd0);
        check("rst_busy_done", {busy, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_mul_ab", {mul_a, mul_b}, 64'd0);
        tick();

        run_op(32'h0000_0002, 32'hFFFF_FFFE, 1'b0, lat, bcnt);
        check("latency", 64'(lat), 64'(MC + 3));
        check("busy_cycles", 64'(bcnt), 64'(MC + 2));
        tick();

        run_op(32'hFFFF_FFFB, 32'h0000_0006, 1'b1, lat, bcnt);
`ifdef MUL_SIGNED_EN
        check("mul_a_mag", {mul_a, mul_b}, {32'd5, 32'd6});
`else
        check("mul_a_pass", {mul_a, mul_b}, {32'hFFFF_FFFB, 32'd6});
`endif
        tick();
        run_op(32'hFFFF_FFFB, 32'h0000_0006, 1'b0, lat, bcnt);
        tick();
        run_op(32'hFFFF_FFFB, 32'hFFFF_FFFA, 1'b1, lat, bcnt);
        tick();
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, lat, bcnt);
        tick();

        // Start pulses and a HI write while busy must be ignored
        dc = done_cnt;
        exp_q.push_back(model(32'd3, 32'd7, 1'b0));
        op_a = 32'd3; op_b = 32'd7; op_signed = 1'b0; start = 1'b1;
        tick();
        while (busy) begin
            start = 1'b1; op_a = 32'd99; hi_we = 1'b1; wdata = 32'h0000_DEAD;
            tick();
        end
        start = 1'b0; hi_we = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("busy_ignore_dones", 64'(done_cnt - dc), 64'd1);

        // Back-to-back: second start issued in the done cycle
        run_op(32'h1234_5678, 32'h0000_0010, 1'b0, lat, bcnt);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bcnt);
        check("b2b_latency", 64'(lat), 64'(MC + 3));
        tick();

        // Direct write together with start
        exp_q.push_back(model(32'd11, 32'd13, 1'b0));
        op_a = 32'd11; op_b = 32'd13; start = 1'b1; hi_we = 1'b1; wdata = 32'h0000_1234;
        tick();
        start = 1'b0; hi_we = 1'b0;
        check("hi_we_with_start", 64'(hi), 64'h1234);
        lat = 1;
        while (!done && lat < 40) begin tick(); lat++; end
        check("hi_we_start_lat", 64'(lat), 64'(MC + 3));
        tick();

        // Both direct writes at once
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        check("hi_lo_we", {hi, lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});

        // Random operands
        for (int i = 0; i < 6; i++) begin
            a = $urandom_range(32'hFFFF_FFFF, 0);
            b = $urandom_range(32'hFFFF_FFFF, 0);
            run_op(a, b, 1'($urandom_range(1, 0)), lat, bcnt);
            tick();
        end

        // Reset in WAIT aborts without done
        dc = done_cnt;
        op_a = 32'd5; op_b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("in_wait", 64'(state_dbg), 64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        for (int i = 0; i < 8; i++) tick();
        check("abort_no_done", 64'(done_cnt - dc), 64'd0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
